// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and BCD digit limits.
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PAUSED,
      ST_RUN,
      ST_EXPIRED
   } state_e;

   localparam logic [3:0] DIGIT_MAX9 = 4'd9;
   localparam logic [3:0] DIGIT_MAX5 = 4'd5;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with clamped load and borrow output to the next digit.
module bcd_down_digit
   import countdown_pkg::*;
#(
   parameter logic [3:0] MAX = DIGIT_MAX9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic [3:0] q,
   output logic       borrow_out
);

   logic [3:0] q_q;
   logic [3:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load) begin
         q_d = (load_val > MAX) ? MAX : load_val;
      end else if (dec) begin
         q_d = (q_q == '0) ? MAX : q_q - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q          = q_q;
   assign borrow_out = dec && !load && (q_q == '0);

endmodule

// File: rtl/countdown_timer.sv
// H:MM:SS BCD countdown timer with prescaler, load/pause/run control and expiry pulse.
module countdown_timer
   import countdown_pkg::*;
#(
   parameter int unsigned DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       load,
   input  logic [3:0] h_in,
   input  logic [3:0] m1_in,
   input  logic [3:0] m0_in,
   input  logic [3:0] s1_in,
   input  logic [3:0] s0_in,
   output logic [3:0] h,
   output logic [3:0] m1,
   output logic [3:0] m0,
   output logic [3:0] s1,
   output logic [3:0] s0,
   output logic       running,
   output logic       expired,
   output logic       done
);

   localparam int unsigned    PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0]  PRE_ONE  = PW'(1);

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          running_q, running_d;
   logic          expired_q, expired_d;
   logic          done_q, done_d;

   logic          load_zero;
   logic          last_sec;
   logic          pre_wrap;
   logic          tick;
   logic          b_s0, b_s1, b_m0, b_m1;
   logic          unused_h_borrow;

   assign load_zero = (h_in == '0) && (m1_in == '0) && (m0_in == '0) &&
                      (s1_in == '0) && (s0_in == '0);
   assign last_sec  = (h == '0) && (m1 == '0) && (m0 == '0) &&
                      (s1 == '0) && (s0 == 4'd1);
   assign pre_wrap  = (pre_q == PRE_LAST);
   // RUN always holds a nonzero value, so a tick can never underflow the chain.
   assign tick      = (state_q == ST_RUN) && enable && pre_wrap && !load;

   bcd_down_digit #(.MAX(DIGIT_MAX9)) u_s0 (
      .clk(clk), .reset(reset), .load(load), .load_val(s0_in),
      .dec(tick), .q(s0), .borrow_out(b_s0)
   );
   bcd_down_digit #(.MAX(DIGIT_MAX5)) u_s1 (
      .clk(clk), .reset(reset), .load(load), .load_val(s1_in),
      .dec(b_s0), .q(s1), .borrow_out(b_s1)
   );
   bcd_down_digit #(.MAX(DIGIT_MAX9)) u_m0 (
      .clk(clk), .reset(reset), .load(load), .load_val(m0_in),
      .dec(b_s1), .q(m0), .borrow_out(b_m0)
   );
   bcd_down_digit #(.MAX(DIGIT_MAX5)) u_m1 (
      .clk(clk), .reset(reset), .load(load), .load_val(m1_in),
      .dec(b_m0), .q(m1), .borrow_out(b_m1)
   );
   bcd_down_digit #(.MAX(DIGIT_MAX9)) u_h (
      .clk(clk), .reset(reset), .load(load), .load_val(h_in),
      .dec(b_m1), .q(h), .borrow_out(unused_h_borrow)
   );

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      if (load) begin
         pre_d   = '0;
         state_d = load_zero ? ST_IDLE : ST_PAUSED;
      end else begin
         case (state_q)
            ST_PAUSED: begin
               if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!enable) begin
                  state_d = ST_PAUSED;
               end else if (pre_wrap) begin
                  pre_d = '0;
                  if (last_sec) state_d = ST_EXPIRED;
               end else begin
                  pre_d = pre_q + PRE_ONE;
               end
            end
            default: ;
         endcase
      end
      running_d = (state_d == ST_RUN);
      expired_d = (state_d == ST_EXPIRED);
      done_d    = (state_q == ST_RUN) && (state_d == ST_EXPIRED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pre_q     <= '0;
         running_q <= 1'b0;
         expired_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         running_q <= running_d;
         expired_q <= expired_d;
         done_q    <= done_d;
      end
   end

   assign running = running_q;
   assign expired = expired_q;
   assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: DIV=1 and DIV=4 timers share stimulus; a seconds-based model predicts outputs.
module tb_countdown_timer;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       load;
   logic [3:0] h_in, m1_in, m0_in, s1_in, s0_in;

   logic [3:0] h_a, m1_a, m0_a, s1_a, s0_a;
   logic       running_a, expired_a, done_a;
   logic [3:0] h_b, m1_b, m0_b, s1_b, s0_b;
   logic       running_b, expired_b, done_b;

   logic [22:0] obs_a, obs_b;
   logic [22:0] q_a[$];
   logic [22:0] q_b[$];

   int n_tests = 0;
   int n_fail  = 0;

   int m_st[2];
   int m_sec[2];
   int m_pre[2];
   bit m_done[2];
   int divs[2] = '{1, 4};

   countdown_timer #(.DIV(1)) u_div1 (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .h_in(h_in), .m1_in(m1_in), .m0_in(m0_in), .s1_in(s1_in), .s0_in(s0_in),
      .h(h_a), .m1(m1_a), .m0(m0_a), .s1(s1_a), .s0(s0_a),
      .running(running_a), .expired(expired_a), .done(done_a)
   );

   countdown_timer #(.DIV(4)) u_div4 (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .h_in(h_in), .m1_in(m1_in), .m0_in(m0_in), .s1_in(s1_in), .s0_in(s0_in),
      .h(h_b), .m1(m1_b), .m0(m0_b), .s1(s1_b), .s0(s0_b),
      .running(running_b), .expired(expired_b), .done(done_b)
   );

   assign obs_a = {h_a, m1_a, m0_a, s1_a, s0_a, running_a, expired_a, done_a};
   assign obs_b = {h_b, m1_b, m0_b, s1_b, s0_b, running_b, expired_b, done_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clampd(input logic [3:0] v, input int mx);
      return (int'(v) > mx) ? mx : int'(v);
   endfunction

   // Model states: 0 idle, 1 paused, 2 run, 3 expired.
   function automatic logic [22:0] exp_vec(input int k);
      int hh, mm, ss;
      hh = m_sec[k] / 3600;
      mm = (m_sec[k] / 60) % 60;
      ss = m_sec[k] % 60;
      return {4'(hh), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
              m_st[k] == 2, m_st[k] == 3, m_done[k]};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_sec[k] = 0; m_pre[k] = 0; m_done[k] = 1'b0;
      end
   endtask

   task automatic step(input logic ld, input logic en, input logic [3:0] hh,
                       input logic [3:0] a1, input logic [3:0] a0,
                       input logic [3:0] b1, input logic [3:0] b0);
      load = ld; enable = en;
      h_in = hh; m1_in = a1; m0_in = a0; s1_in = b1; s0_in = b0;
      for (int k = 0; k < 2; k++) begin
         m_done[k] = 1'b0;
         if (ld) begin
            m_sec[k] = clampd(hh, 9) * 3600 + clampd(a1, 5) * 600 + clampd(a0, 9) * 60 +
                       clampd(b1, 5) * 10 + clampd(b0, 9);
            m_pre[k] = 0;
            m_st[k]  = (m_sec[k] == 0) ? 0 : 1;
         end else if (m_st[k] == 1) begin
            if (en) m_st[k] = 2;
         end else if (m_st[k] == 2) begin
            if (!en) m_st[k] = 1;
            else if (m_pre[k] == divs[k] - 1) begin
               m_pre[k] = 0;
               m_sec[k] = m_sec[k] - 1;
               if (m_sec[k] == 0) begin
                  m_st[k] = 3; m_done[k] = 1'b1;
               end
            end else m_pre[k] = m_pre[k] + 1;
         end
      end
      q_a.push_back(exp_vec(0));
      q_b.push_back(exp_vec(1));
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic run(input logic en, input int n);
      for (int i = 0; i < n; i++) step(1'b0, en, '0, '0, '0, '0, '0);
   endtask

   always @(posedge clk) begin
      #1;
      if (q_a.size() > 0) check("sb_div1", obs_a, q_a.pop_front());
      if (q_b.size() > 0) check("sb_div4", obs_b, q_b.pop_front());
   end

   initial begin
      reset = 1'b1; enable = 1'b0; load = 1'b0;
      h_in = '0; m1_in = '0; m0_in = '0; s1_in = '0; s0_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_div1", obs_a, 0);
      check("rst_div4", obs_b, 0);
      reset = 1'b0;

      // 0:00:03 countdown at DIV=1, enable held through the load
      step(1'b1, 1'b1, 0, 0, 0, 0, 3);
      check("load_paused", running_a, 0);
      run(1'b1, 1);
      check("run_after_load", running_a, 1);
      run(1'b1, 3);
      check("done_pulse", done_a, 1);
      check("at_zero", obs_a[22:3], 0);
      run(1'b1, 1);
      check("done_single", done_a, 0);
      check("expired_hold", expired_a, 1);
      run(1'b1, 4);

      // Full borrow chain and minute borrow
      step(1'b1, 1'b1, 1, 0, 0, 0, 0);
      run(1'b1, 2);
      check("chain_1h", obs_a[22:3], 20'h05959);
      step(1'b1, 1'b1, 0, 1, 0, 0, 0);
      run(1'b1, 2);
      check("chain_10m", obs_a[22:3], 20'h00959);

      // DIV=4 latency and pause holding the prescaler
      step(1'b1, 1'b1, 0, 0, 0, 0, 2);
      run(1'b1, 1);
      run(1'b1, 3);
      check("div4_pre3", s0_b, 2);
      run(1'b1, 1);
      check("div4_first", s0_b, 1);
      run(1'b1, 2);
      run(1'b0, 3);
      check("div4_paused", running_b, 0);
      run(1'b1, 2);
      check("div4_resume", s0_b, 1);
      run(1'b1, 1);
      check("div4_second", s0_b, 0);
      check("div4_done", done_b, 1);

      // Clamping and zero load
      step(1'b1, 1'b0, 12, 8, 0, 0, 15);
      check("clamp_div1", obs_a[22:3], 20'h95009);
      check("clamp_div4", obs_b[22:3], 20'h95009);
      step(1'b1, 1'b1, 0, 0, 0, 0, 0);
      run(1'b1, 2);
      check("zero_load", obs_a, 0);

      // Load racing the final decrement
      step(1'b1, 1'b1, 0, 0, 0, 0, 1);
      run(1'b1, 1);
      step(1'b1, 1'b1, 0, 0, 0, 0, 7);
      check("load_wins", obs_a, 23'h7 << 3);
      run(1'b1, 3);

      // Asynchronous reset mid-RUN
      step(1'b1, 1'b1, 0, 0, 0, 0, 5);
      run(1'b1, 1);
      reset = 1'b1;
      #1;
      check("async_rst_div1", obs_a, 0);
      check("async_rst_div4", obs_b, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      run(1'b1, 2);

      // Enable ignored in EXPIRED; reload leaves it
      step(1'b1, 1'b1, 0, 0, 0, 0, 1);
      run(1'b1, 2);
      run(1'b0, 1);
      run(1'b1, 1);
      run(1'b0, 1);
      check("exp_hold", expired_a, 1);
      step(1'b1, 1'b0, 0, 0, 0, 0, 1);
      check("exp_reload", expired_a, 0);
      check("exp_reload_run", running_a, 0);

      for (int i = 0; i < 120; i++) begin
         step(($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
              '0, '0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter DIV, default 1, enabled-RUN cycles per one-second decrement (range 1..2^16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  level; 1 = count, 0 = pause.
REQ-005 load  input  1  one-cycle strobe; captures the *_in digits.
REQ-006 h_in, m1_in, m0_in, s1_in, s0_in  input  4 each  BCD preset digits.
REQ-007 h, m1, m0, s1, s0  output  4 each  current BCD remaining time (H:MM:SS).
REQ-008 running  output  1  high while state is RUN.
REQ-009 expired  output  1  high while state is EXPIRED.
REQ-010 done  output  1  one-cycle pulse on the RUN-to-EXPIRED transition.

Function
REQ-011 The digit ranges SHALL be: s0 0..9, s1 0..5, m0 0..9, m1 0..5, h 0..9 (max 9:59:59).
REQ-012 FSM states SHALL be: IDLE, PAUSED, RUN, EXPIRED.
REQ-013 Load SHALL clamp each *_in digit above its max to that max (e.g. s1_in=7 -> 5).
REQ-014 Load SHALL take priority over every other event in every state, and SHALL clear the prescaler.
REQ-015 Load transitions SHALL be: zero value -> IDLE; nonzero value -> PAUSED, even when enable=1.
REQ-016 In PAUSED, enable=1 SHALL move the FSM to RUN on the next edge.
REQ-017 In RUN, enable=0 SHALL move the FSM to PAUSED with no prescaler advance in that cycle.
REQ-018 In IDLE and EXPIRED, enable SHALL be ignored.
REQ-019 Prescaler: in RUN with enable=1 it SHALL count 0..DIV-1.
REQ-020 At DIV-1 the prescaler SHALL wrap to 0, and the time SHALL decrement by one second on the same edge.
REQ-021 The prescaler SHALL hold its value in PAUSED.
REQ-022 Decrement SHALL be BCD with borrow chain s0->s1->m0->m1->h; a digit at 0 that receives a borrow SHALL reload its max and pass the borrow on.
REQ-023 A decrement that yields 0:00:00 SHALL move the FSM to EXPIRED and assert done for exactly that next cycle.
REQ-024 The counter SHALL never wrap below 0:00:00.
REQ-025 Latency: the first decrement SHALL occur DIV cycles after the first RUN cycle with enable=1.
REQ-026 Loading zero SHALL never assert done or expired.
REQ-027 running and expired SHALL be registered, state-decoded outputs; done SHALL be registered.

Reset
REQ-028 On reset all digits SHALL be 0, the prescaler 0, the state IDLE, and running, expired and done 0.
REQ-029 Reset asserted mid-RUN SHALL abort the count immediately with no done pulse.
REQ-030 The first operative edge after reset deassertion SHALL obey REQ-014..REQ-024.

Structure
REQ-031 The shared package countdown_pkg SHALL hold the state enum and the digit max constants (9, 5).
REQ-032 The sub-module bcd_down_digit SHALL implement one digit: parameter MAX; ports clk, reset, load, load_val, dec, q, borrow_out; instantiated five times.
REQ-033 The FSM and prescaler SHALL reside in countdown_timer.
REQ-034 Expected size is 150-300 RTL lines.

Verification
REQ-035 DIV=1: load 0:00:03, enable=1 -> running on the following edge; digits 2,1,0 on successive cycles; done pulses once; expired=1 stays; digits hold 0.
REQ-036 DIV=1: load 1:00:00 and run one decrement -> 0:59:59 (full borrow chain); load 0:10:00 -> 0:09:59.
REQ-037 DIV=4: load 0:00:02 and run -> first decrement on the 4th enabled RUN cycle; enable=0 after 2 RUN cycles, then re-enable -> decrement after 2 more RUN cycles.
REQ-038 Load of h=12, m1=8, s0=15 (m0=s1=0) -> outputs 9:50:09; load of 0:00:00 -> IDLE, no done, expired=0.
REQ-039 Load asserted on the same cycle as the final decrement -> loaded value wins, no done; reset mid-RUN at 0:00:05 -> outputs 0 asynchronously, IDLE, no done.
REQ-040 In EXPIRED, enable toggling -> no change; load 0:00:01 -> PAUSED, expired=0.
